// File: rtl/brazo_pkg.sv
// Shared definitions for the arm pose sequencer: state encoding and reset position.
package brazo_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      IDLE  = 2'd0,
      ACCEL = 2'd1,
      MEM   = 2'd2
   } state_t;

   localparam int CENTER_DEF = 128;

endpackage

// File: rtl/arm_pose_sequencer_if.sv
// Bundle between the accelerometer mapping / buttons and the per-servo PWM generators.
interface arm_pose_sequencer_if
   import brazo_pkg::*;
#(
   parameter int N_SERVO = 4,
   parameter int POS_W   = 8,
   parameter int DEPTH   = 16
);
   localparam int AW = $clog2(DEPTH);

   logic                     enable;
   logic                     btn_mem;
   logic                     btn_save;
   logic                     btn_clear;
   logic [N_SERVO*POS_W-1:0] accel_pos;
   // No backpressure: servo_pos is meaningful whenever servo_valid is high, the PWM side always accepts.
   logic [N_SERVO*POS_W-1:0] servo_pos;
   logic                     servo_valid;
   logic [MODE_W-1:0]        mode;
   logic [AW:0]              pose_count;
   logic [AW-1:0]            play_idx;
   logic                     mem_full;

   modport slave (
      input  enable, btn_mem, btn_save, btn_clear, accel_pos,
      output servo_pos, servo_valid, mode, pose_count, play_idx, mem_full
   );

   modport master (
      output enable, btn_mem, btn_save, btn_clear, accel_pos,
      input  servo_pos, servo_valid, mode, pose_count, play_idx, mem_full
   );

endinterface

// File: rtl/arm_pose_mem.sv
// Pose storage: one synchronous write port, one registered read port, contents not reset.
module arm_pose_mem #(
   parameter int DEPTH = 16,
   parameter int W     = 32
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [W-1:0]             i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [W-1:0]             o_rdata
);

   logic [W-1:0] r_mem [DEPTH];
   logic [W-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      r_rdata <= r_mem[i_raddr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/arm_pose_sequencer.sv
// Mode controller: live accelerometer forwarding with pose recording, and looped pose playback.
module arm_pose_sequencer
   import brazo_pkg::*;
#(
   parameter int N_SERVO   = 4,
   parameter int POS_W     = 8,
   parameter int DEPTH     = 16,
   parameter int DWELL_CYC = 50_000_000,
   parameter int CENTER    = CENTER_DEF
) (
   input  logic               clk,
   input  logic               rst,
   arm_pose_sequencer_if.slave bus
);

   localparam int W  = N_SERVO * POS_W;
   localparam int AW = $clog2(DEPTH);
   localparam int DW = $clog2(DWELL_CYC);
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
   localparam logic [AW:0]   COUNT_FULL = (AW+1)'(DEPTH);
   localparam logic [W-1:0]  CENTER_POS = {N_SERVO{POS_W'(CENTER)}};

   state_t         r_state;
   state_t         w_next_state;
   logic [W-1:0]   r_servo_pos;
   logic [AW:0]    r_pose_count;
   logic [AW-1:0]  r_play_idx;
   logic [AW-1:0]  w_next_idx;
   logic [DW-1:0]  r_dwell;
   logic [DW-1:0]  w_next_dwell;
   logic [W-1:0]   w_rd_data;
   logic           w_mem_full;
   logic           w_has_poses;
   logic           w_last_idx;
   logic           w_save;
   logic           w_clear;

   assign w_mem_full  = (r_pose_count == COUNT_FULL);
   assign w_has_poses = (r_pose_count != '0);
   assign w_last_idx  = ({1'b0, r_play_idx} == (r_pose_count - (AW+1)'(1)));

   assign w_clear = bus.btn_clear && ((r_state == IDLE) || (r_state == ACCEL));
   assign w_save  = bus.btn_save && !bus.btn_clear && !w_mem_full && (r_state == ACCEL);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (!bus.enable) begin
         w_next_state = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (!bus.btn_mem) begin
                  w_next_state = ACCEL;
               end else if (w_has_poses) begin
                  w_next_state = MEM;
               end
            end
            ACCEL: begin
               if (bus.btn_mem && w_has_poses) begin
                  w_next_state = MEM;
               end
            end
            MEM: begin
               if (!bus.btn_mem) begin
                  w_next_state = ACCEL;
               end
            end
            default: w_next_state = IDLE;
         endcase
      end
   end

   // Playback index is also the read address, so read data lines up with play_idx one edge later.
   always_comb begin
      w_next_idx   = r_play_idx;
      w_next_dwell = r_dwell;
      if ((w_next_state == MEM) && (r_state != MEM)) begin
         w_next_idx   = '0;
         w_next_dwell = '0;
      end else if (r_state == MEM) begin
         if (r_dwell == DWELL_LAST) begin
            w_next_dwell = '0;
            w_next_idx   = w_last_idx ? '0 : r_play_idx + AW'(1);
         end else begin
            w_next_dwell = r_dwell + DW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_servo_pos  <= CENTER_POS;
         r_pose_count <= '0;
         r_play_idx   <= '0;
         r_dwell      <= '0;
      end else begin
         r_play_idx <= w_next_idx;
         r_dwell    <= w_next_dwell;
         if (w_clear) begin
            r_pose_count <= '0;
         end else if (w_save) begin
            r_pose_count <= r_pose_count + (AW+1)'(1);
         end
         // With enable low the servos keep the last commanded pose.
         if (bus.enable) begin
            case (r_state)
               ACCEL:   r_servo_pos <= bus.accel_pos;
               MEM:     r_servo_pos <= w_rd_data;
               default: r_servo_pos <= r_servo_pos;
            endcase
         end
      end
   end

   arm_pose_mem #(
      .DEPTH (DEPTH),
      .W     (W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_save),
      .i_waddr (r_pose_count[AW-1:0]),
      .i_wdata (bus.accel_pos),
      .i_raddr (w_next_idx),
      .o_rdata (w_rd_data)
   );

   assign bus.servo_pos   = r_servo_pos;
   assign bus.servo_valid = (r_state != IDLE);
   assign bus.mode        = r_state;
   assign bus.pose_count  = r_pose_count;
   assign bus.play_idx    = r_play_idx;
   assign bus.mem_full    = w_mem_full;

endmodule

// File: tb/tb_arm_pose_sequencer.sv
// Directed bench for arm_pose_sequencer with a short dwell so playback loops are quick to observe.
module tb_arm_pose_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [31:0] abc [3];

   always #5 clk = ~clk;

   arm_pose_sequencer_if #(.N_SERVO(4), .POS_W(8), .DEPTH(16)) bus ();

   arm_pose_sequencer #(
      .N_SERVO   (4),
      .POS_W     (8),
      .DEPTH     (16),
      .DWELL_CYC (4),
      .CENTER    (128)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_save(input logic [31:0] pos);
      bus.accel_pos = pos;
      bus.btn_save  = 1'b1;
      tick(1);
      bus.btn_save  = 1'b0;
   endtask

   initial begin
      abc[0] = 32'h11111111;
      abc[1] = 32'h22222222;
      abc[2] = 32'h33333333;
      bus.enable    = 1'b0;
      bus.btn_mem   = 1'b0;
      bus.btn_save  = 1'b0;
      bus.btn_clear = 1'b0;
      bus.accel_pos = '0;

      // reset
      tick(2);
      rst = 1'b0;
      check("rst_mode",  bus.mode, 0);
      check("rst_pos",   bus.servo_pos, 32'h80808080);
      check("rst_valid", bus.servo_valid, 0);
      check("rst_count", bus.pose_count, 0);
      check("rst_idx",   bus.play_idx, 0);
      check("rst_full",  bus.mem_full, 0);

      // empty playback guard from IDLE
      bus.enable  = 1'b1;
      bus.btn_mem = 1'b1;
      tick(1);
      check("guard_idle_mode", bus.mode, 0);
      tick(1);
      check("guard_idle_mode2", bus.mode, 0);

      // live forwarding
      bus.btn_mem   = 1'b0;
      bus.accel_pos = 32'h10203040;
      tick(1);
      check("live_mode", bus.mode, 1);
      check("live_pos_hold", bus.servo_pos, 32'h80808080);
      tick(1);
      check("live_pos", bus.servo_pos, 32'h10203040);
      check("live_valid", bus.servo_valid, 1);

      // empty playback guard from ACCEL
      bus.btn_mem = 1'b1;
      tick(1);
      check("guard_accel_mode", bus.mode, 1);
      bus.btn_mem = 1'b0;

      // record A, B, C then loop
      pulse_save(abc[0]);
      check("rec_count1", bus.pose_count, 1);
      pulse_save(abc[1]);
      pulse_save(abc[2]);
      check("rec_count3", bus.pose_count, 3);
      bus.btn_mem = 1'b1;
      tick(1);
      check("play_mode", bus.mode, 2);
      check("play_idx0", bus.play_idx, 0);
      check("play_pos0", bus.servo_pos, abc[2]);
      for (int k = 1; k <= 13; k++) begin
         tick(1);
         check("play_pos", bus.servo_pos, abc[((k - 1) / 4) % 3]);
         check("play_idx", bus.play_idx, (k / 4) % 3);
      end

      // save and clear ignored during playback
      bus.btn_save = 1'b1;
      tick(1);
      bus.btn_save = 1'b0;
      check("mem_save_ignored", bus.pose_count, 3);
      bus.btn_clear = 1'b1;
      tick(1);
      bus.btn_clear = 1'b0;
      check("mem_clear_ignored", bus.pose_count, 3);
      check("mem_idx15", bus.play_idx, 0);
      check("mem_pos15", bus.servo_pos, abc[0]);

      // enable dropped in MEM
      bus.enable = 1'b0;
      tick(1);
      check("dis_mode", bus.mode, 0);
      check("dis_valid", bus.servo_valid, 0);
      check("dis_pos", bus.servo_pos, abc[0]);
      check("dis_count", bus.pose_count, 3);

      // back into MEM, then reset mid-playback
      bus.enable = 1'b1;
      tick(1);
      check("reenter_mode", bus.mode, 2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("rstmem_pos", bus.servo_pos, 32'h80808080);
      check("rstmem_count", bus.pose_count, 0);
      check("rstmem_mode", bus.mode, 0);
      check("rstmem_valid", bus.servo_valid, 0);
      check("rstmem_idx", bus.play_idx, 0);

      // fill memory, 17th save ignored
      bus.btn_mem = 1'b0;
      tick(1);
      check("fill_mode", bus.mode, 1);
      for (int i = 0; i < 16; i++) begin
         pulse_save({4{8'(8'h40 + i)}});
      end
      check("fill_count", bus.pose_count, 16);
      check("fill_full", bus.mem_full, 1);
      pulse_save(32'h50505050);
      check("fill_count17", bus.pose_count, 16);
      check("fill_full17", bus.mem_full, 1);

      // playback shows first recorded pose intact (no wrap on 17th save)
      bus.btn_mem = 1'b1;
      tick(1);
      check("fill_play_mode", bus.mode, 2);
      tick(1);
      check("fill_play_pos0", bus.servo_pos, 32'h40404040);
      tick(4);
      check("fill_play_pos1", bus.servo_pos, 32'h41414141);
      check("fill_play_idx1", bus.play_idx, 1);

      // clear from ACCEL
      bus.btn_mem = 1'b0;
      tick(1);
      check("back_accel", bus.mode, 1);
      bus.btn_clear = 1'b1;
      tick(1);
      bus.btn_clear = 1'b0;
      check("clear_count", bus.pose_count, 0);
      check("clear_full", bus.mem_full, 0);

      // save and clear together: clear wins
      pulse_save(32'hAAAAAAAA);
      check("sc_pre_count", bus.pose_count, 1);
      bus.accel_pos = 32'hBBBBBBBB;
      bus.btn_save  = 1'b1;
      bus.btn_clear = 1'b1;
      tick(1);
      bus.btn_save  = 1'b0;
      bus.btn_clear = 1'b0;
      check("sc_count", bus.pose_count, 0);
      bus.btn_mem = 1'b1;
      tick(2);
      check("sc_guard_mode", bus.mode, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/arm_pose_sequencer.md
Name: arm_pose_sequencer

Overview:
Mode controller and pose sequencer for the robotic arm servos. In ACCEL mode it forwards live accelerometer-mapped positions to the servo PWM generators and records poses on demand. In MEM mode it replays the recorded poses in a loop, holding each pose for a fixed dwell time. It sits between the accelerometer mapping logic and the per-servo PWM generators.

Parameters:
N_SERVO, 4, number of servo channels
POS_W, 8, position width per servo
DEPTH, 16, maximum stored poses (power of 2); AW = clog2(DEPTH)
DWELL_CYC, 50_000_000, clock cycles each pose is held during playback (≥2)
CENTER, 128, per-servo position driven after reset

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  global arm enable (level)
btn_mem  in  1  mode select level: 0 = live ACCEL, 1 = MEM playback
btn_save  in  1  single-cycle pulse (debounced upstream): store current accel_pos
btn_clear  in  1  single-cycle pulse: erase recorded sequence
accel_pos  in  N_SERVO*POS_W  live target positions, servo 0 in LSBs
servo_pos  out  N_SERVO*POS_W  positions to the PWM generators
servo_valid  out  1  servo_pos is being actively driven (state ≠ IDLE)
mode  out  2  current state encoding
pose_count  out  AW+1  number of stored poses (0..DEPTH)
play_idx  out  AW  index of the pose currently commanded in MEM
mem_full  out  1  pose_count == DEPTH (combinational from register)

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; servo_pos = CENTER in every field; servo_valid=0; pose_count=0; play_idx=0; dwell_cnt=0. Memory contents are not reset.
- States: IDLE=0, ACCEL=1, MEM=2. mode = state.
- Any state, enable=0 → IDLE next cycle. servo_pos holds its last value; servo_valid=0.
- IDLE, enable=1: btn_mem=0 → ACCEL. btn_mem=1 and pose_count>0 → MEM. btn_mem=1 and pose_count=0 → stay IDLE.
- ACCEL: servo_pos <= accel_pos every cycle (1-cycle latency). servo_valid=1.
  - btn_save=1 and !mem_full → write accel_pos to mem[pose_count]; pose_count+1.
  - btn_save when full → ignored; no write, no wrap.
  - btn_mem=1 and pose_count>0 (registered value before any same-cycle save) → MEM.
  - btn_mem=1 with pose_count=0 → stay ACCEL.
- Entry to MEM: play_idx<=0 and dwell_cnt<=0 on the transition edge.
- MEM: pose memory is read at play_idx with a registered read; servo_pos <= mem[play_idx] one cycle later. servo_valid=1.
  - dwell_cnt increments each cycle.
  - At dwell_cnt==DWELL_CYC-1: dwell_cnt<=0; play_idx <= (play_idx==pose_count-1) ? 0 : play_idx+1.
  - btn_mem=0 → ACCEL. btn_save and btn_clear are ignored in MEM.
- btn_clear is honoured in IDLE and ACCEL only: pose_count<=0.
- btn_save and btn_clear in the same ACCEL cycle: clear wins; no write.
- Reset mid-playback: all outputs return to reset values on the next edge; pose_count=0, so the recorded sequence is logically lost.
- btn_save in IDLE is ignored.

Decomposition:
- Shared package brazo_pkg holds the state localparams IDLE/ACCEL/MEM, the mode width, and the CENTER default.
- One sub-module, arm_pose_mem: DEPTH x (N_SERVO*POS_W) storage with one synchronous write port and a registered read port, no reset on contents.
- FSM, counters and output muxing live in arm_pose_sequencer.

Test Plan:
- Reset: assert rst for 2 cycles → mode=0, servo_pos=0x80808080, servo_valid=0, pose_count=0, play_idx=0, mem_full=0.
- Live forwarding: enable=1, btn_mem=0, accel_pos=0x10203040 → mode=1 after 1 clk; servo_pos=0x10203040 and servo_valid=1 the following clk.
- Record and loop: with DWELL_CYC=4, save A=0x11111111, B=0x22222222, C=0x33333333, then btn_mem=1 → pose_count=3; servo_pos cycles A,B,C,A each held 4 cycles; play_idx cycles 0,1,2,0.
- Fill and clear: 17 save pulses → pose_count=16, mem_full=1, 17th save ignored; btn_clear → pose_count=0, mem_full=0. Save and clear in the same cycle → pose_count=0, no write.
- Empty playback guard: pose_count=0, btn_mem=1 from IDLE → mode stays 0; from ACCEL → mode stays 1.
- Mid-operation events:
  - enable dropped during MEM → mode=0 next cycle, servo_valid=0, servo_pos unchanged.
  - rst during MEM → servo_pos=0x80808080, pose_count=0.
